vc_pmem_arbiter: RTL and testbench
==================================

# vc_pmem_arbiter

Arbiter and scheduler for the single physical-memory port shared by the L2 cache and the victim cache (VC). It serves three requesters: L2 miss fills, forced VC dirty-victim evictions, and background cleaning of dirty VC lines while L2 is idle. It sits between the L2/VC controllers and pmem, and owns all pmem handshaking.

## Interface
- WAYS, 8: VC associativity; way index width is $clog2(WAYS)
- LINE_W, 256: cache line width (lc3b_c_line)
- ADDR_W, 16: line address width (lc3b_word)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- l2_idle  in  1  L2 controller has no outstanding access
- l2_pmem_read  in  1  L2 miss fill request; held until l2_pmem_resp
- l2_pmem_addr  in  ADDR_W  fill address
- l2_pmem_rdata  out  LINE_W  fill data; valid with l2_pmem_resp
- l2_pmem_resp  out  1  one-cycle fill completion pulse
- vc_evict_req  in  1  VC needs a dirty victim written back; held until vc_evict_ack
- vc_evict_addr  in  ADDR_W  evicted line address
- vc_evict_wdata  in  LINE_W  evicted line data
- vc_evict_ack  out  1  one-cycle eviction completion pulse
- vc_dirty_vec  in  WAYS  per-way dirty bits from the VC
- vc_way_write  in  1  VC is writing a line this cycle
- vc_way_write_idx  in  log2(WAYS)  way being written
- clean_way  out  log2(WAYS)  way selected for cleaning; VC reads it combinationally
- clean_addr  in  ADDR_W  address of line at clean_way
- clean_wdata  in  LINE_W  data of line at clean_way
- clean_done  out  1  one-cycle pulse: clear dirty bit of clean_way
- pmem_read, pmem_write  out  1  pmem commands, held until pmem_resp
- pmem_address  out  ADDR_W
- pmem_wdata  out  LINE_W
- pmem_rdata  in  LINE_W
- pmem_resp  in  1

## Operation
- FSM states: IDLE, FILL, EVICT, CLEAN.
- IDLE priority: vc_evict_req → EVICT; else l2_pmem_read → FILL; else l2_idle && |vc_dirty_vec → CLEAN; else stay.
- On entry to CLEAN: latch clean_way (lowest-index set bit of vc_dirty_vec), clean_addr and clean_wdata into registers. pmem is driven from the latched copies for the whole transaction.
- FILL: pmem_read=1, pmem_address=l2_pmem_addr. On pmem_resp: l2_pmem_resp=1, l2_pmem_rdata=pmem_rdata (pass-through), then go to IDLE.
- EVICT: pmem_write=1, address/data from vc_evict_*. On pmem_resp: vc_evict_ack=1, then go to IDLE.
- CLEAN: pmem_write=1 from latched values. It is non-preemptive; a new L2 request waits for pmem_resp. Set stale flag when vc_way_write && vc_way_write_idx==clean_way, including the entry cycle after latching. On pmem_resp: clean_done = !stale, then go to IDLE and clear stale.
- A stale clean still completes to pmem, but the dirty bit stays set, so the line is re-cleaned later.
- pmem_read and pmem_write are never both 1.

## Timing
- All outputs are 0 on reset, and clean_way is 0. The FSM goes to IDLE and the stale flag clears.
- Reset mid-transaction abandons it. A pmem_resp arriving while in IDLE is ignored.
- A request sampled in IDLE at cycle N puts the command on pmem at N+1.
- Responses are combinational with pmem_resp in the same cycle. The FSM is in IDLE for at least one cycle between transactions.
- Minimum fill latency is 2 cycles plus pmem latency.
- Simultaneous evict and fill: evict wins; fill is served immediately after (evict → IDLE → FILL).
- vc_dirty_vec==0 with l2_idle: stay in IDLE. l2_idle dropping mid-CLEAN has no effect.

## Structure
- Add to lc3b_types: enum vc_arb_state_t {IDLE, FILL, EVICT, CLEAN}; lc3b_word and lc3b_c_line are already present.
- Sub-module vc_dirty_picker: WAYS-bit lowest-set-bit priority encoder producing way index and an any-dirty flag.

## Test plan
- Reset, then l2_pmem_read with addr 0x1200 and pmem_resp after 3 cycles: pmem_read is high cycles 1–3, then l2_pmem_resp is a single pulse carrying pmem_rdata.
- vc_evict_req and l2_pmem_read in the same cycle: EVICT runs first (pmem_write, vc_evict_addr) → vc_evict_ack → one IDLE cycle → FILL.
- l2_idle=1, vc_dirty_vec=8'b0010_1000: clean_way=3, a write of the latched line, clean_done pulses. Then with vc_dirty_vec=8'b0010_0000, way 5 is cleaned.
- During CLEAN of way 3, pulse vc_way_write with idx 3: the write completes and clean_done stays 0. With idx 4 instead, clean_done=1.
- l2_pmem_read rises mid-CLEAN: the clean finishes first, then FILL is issued; there is no overlapping pmem command.
- Assert rst during FILL: all outputs go to 0 next cycle, and a later pmem_resp produces no l2_pmem_resp.

Source files
------------

// File: rtl/vc_pmem_arbiter_pkg.sv
// vc_pmem_arbiter_pkg
// Shared types for the victim-cache / L2 physical-memory arbiter.
//   lc3b_word       : 16-bit line address
//   lc3b_c_line     : 256-bit cache line
//   vc_arb_state_t  : arbiter FSM state encoding
package vc_pmem_arbiter_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [255:0] lc3b_c_line;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    EVICT = 2'd2,
    CLEAN = 2'd3
  } vc_arb_state_t;

endpackage

// File: rtl/vc_pmem_arbiter_if.sv
// vc_pmem_arbiter_if
// Physical-memory port bundle shared by the arbiter and the memory.
//   pmem_read / pmem_write : commands, held until pmem_resp
//   pmem_address           : line address
//   pmem_wdata             : write data
//   pmem_rdata             : read data, valid with pmem_resp
//   pmem_resp              : transaction completion
// master: arbiter side; slave: memory side.
interface vc_pmem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = 256
);

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );

endinterface

// File: rtl/vc_pmem_arbiter_dirty_picker.sv
// vc_dirty_picker
// Lowest-set-bit priority encoder over the VC dirty vector.
//   dirty     in  WAYS   per-way dirty bits
//   idx       out IDX_W  index of the lowest set bit (0 when none set)
//   any_dirty out 1      at least one bit set
module vc_dirty_picker #(
  parameter int unsigned WAYS  = 8,
  parameter int unsigned IDX_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic [WAYS-1:0]  dirty,
  output logic [IDX_W-1:0] idx,
  output logic             any_dirty
);

  always_comb begin
    idx       = '0;
    any_dirty = 1'b0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (dirty[i] && !any_dirty) begin
        idx       = IDX_W'(i);
        any_dirty = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vc_pmem_arbiter.sv
// vc_pmem_arbiter
// Schedules the single pmem port between L2 miss fills, forced VC dirty
// evictions and background cleaning of dirty VC lines while L2 is idle.
//   clk, rst            clock, synchronous active-high reset
//   l2_idle             L2 has no outstanding access
//   l2_pmem_read/addr   L2 fill request (held until l2_pmem_resp)
//   l2_pmem_rdata/resp  fill data and one-cycle completion pulse
//   vc_evict_req/addr/wdata, vc_evict_ack   forced eviction handshake
//   vc_dirty_vec        per-way dirty bits
//   vc_way_write/_idx   VC line write this cycle
//   clean_way           way being (or about to be) cleaned; VC answers
//                       combinationally on clean_addr/clean_wdata
//   clean_done          one-cycle pulse: clear dirty bit of clean_way
//   pmem                physical-memory port (master side)
module vc_pmem_arbiter
  import vc_pmem_arbiter_pkg::*;
#(
  parameter int unsigned WAYS   = 8,
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              l2_idle,
  input  logic              l2_pmem_read,
  input  logic [ADDR_W-1:0] l2_pmem_addr,
  output logic [LINE_W-1:0] l2_pmem_rdata,
  output logic              l2_pmem_resp,
  input  logic              vc_evict_req,
  input  logic [ADDR_W-1:0] vc_evict_addr,
  input  logic [LINE_W-1:0] vc_evict_wdata,
  output logic              vc_evict_ack,
  input  logic [WAYS-1:0]   vc_dirty_vec,
  input  logic              vc_way_write,
  input  logic [WAY_W-1:0]  vc_way_write_idx,
  output logic [WAY_W-1:0]  clean_way,
  input  logic [ADDR_W-1:0] clean_addr,
  input  logic [LINE_W-1:0] clean_wdata,
  output logic              clean_done,
  vc_pmem_arbiter_if.master pmem
);

  vc_arb_state_t     state, state_next;
  logic [WAY_W-1:0]  pick_idx;
  logic              pick_any;
  logic [WAY_W-1:0]  clean_way_q;
  logic [ADDR_W-1:0] clean_addr_q;
  logic [LINE_W-1:0] clean_wdata_q;
  logic              stale_q;
  logic              start_clean;
  logic              write_hit;

  vc_dirty_picker #(.WAYS(WAYS), .IDX_W(WAY_W)) u_picker (
    .dirty     (vc_dirty_vec),
    .idx       (pick_idx),
    .any_dirty (pick_any)
  );

  // In IDLE the VC is shown the candidate way so that clean_addr/clean_wdata
  // are valid for latching on the entry edge; afterwards the latched way.
  assign clean_way   = (state == CLEAN) ? clean_way_q : pick_idx;
  assign start_clean = (state == IDLE) && (state_next == CLEAN);
  assign write_hit   = vc_way_write && (vc_way_write_idx == clean_way);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (vc_evict_req)             state_next = EVICT;
        else if (l2_pmem_read)        state_next = FILL;
        else if (l2_idle && pick_any) state_next = CLEAN;
      end
      FILL, EVICT, CLEAN: begin
        if (pmem.pmem_resp) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A VC write to the chosen way on the latch cycle or any CLEAN cycle makes
  // the pmem copy stale, so the dirty bit must survive this clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      clean_way_q   <= '0;
      clean_addr_q  <= '0;
      clean_wdata_q <= '0;
      stale_q       <= 1'b0;
    end else begin
      if (start_clean) begin
        clean_way_q   <= pick_idx;
        clean_addr_q  <= clean_addr;
        clean_wdata_q <= clean_wdata;
      end
      if (state == CLEAN && pmem.pmem_resp)
        stale_q <= 1'b0;
      else if ((start_clean || state == CLEAN) && write_hit)
        stale_q <= 1'b1;
    end
  end

  always_comb begin
    pmem.pmem_read    = 1'b0;
    pmem.pmem_write   = 1'b0;
    pmem.pmem_address = '0;
    pmem.pmem_wdata   = '0;
    l2_pmem_rdata     = '0;
    l2_pmem_resp      = 1'b0;
    vc_evict_ack      = 1'b0;
    clean_done        = 1'b0;
    unique case (state)
      FILL: begin
        pmem.pmem_read    = 1'b1;
        pmem.pmem_address = l2_pmem_addr;
        l2_pmem_rdata     = pmem.pmem_rdata;
        l2_pmem_resp      = pmem.pmem_resp;
      end
      EVICT: begin
        pmem.pmem_write   = 1'b1;
        pmem.pmem_address = vc_evict_addr;
        pmem.pmem_wdata   = vc_evict_wdata;
        vc_evict_ack      = pmem.pmem_resp;
      end
      CLEAN: begin
        pmem.pmem_write   = 1'b1;
        pmem.pmem_address = clean_addr_q;
        pmem.pmem_wdata   = clean_wdata_q;
        clean_done        = pmem.pmem_resp && !(stale_q || write_hit);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vc_pmem_arbiter.sv
module tb_vc_pmem_arbiter;

  localparam int unsigned WAYS   = 8;
  localparam int unsigned LINE_W = 256;
  localparam int unsigned ADDR_W = 16;

  localparam int K_FILL  = 0;
  localparam int K_EVICT = 1;
  localparam int K_CLEAN = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              l2_idle;
  logic              l2_pmem_read;
  logic [ADDR_W-1:0] l2_pmem_addr;
  logic [LINE_W-1:0] l2_pmem_rdata;
  logic              l2_pmem_resp;
  logic              vc_evict_req;
  logic [ADDR_W-1:0] vc_evict_addr;
  logic [LINE_W-1:0] vc_evict_wdata;
  logic              vc_evict_ack;
  logic [WAYS-1:0]   vc_dirty_vec;
  logic              vc_way_write;
  logic [2:0]        vc_way_write_idx;
  logic [2:0]        clean_way;
  logic [ADDR_W-1:0] clean_addr;
  logic [LINE_W-1:0] clean_wdata;
  logic              clean_done;
  logic [3:0]        vc_gen;

  always #5 clk = ~clk;

  vc_pmem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) pmem_bus ();

  vc_pmem_arbiter #(.WAYS(WAYS), .LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .l2_idle          (l2_idle),
    .l2_pmem_read     (l2_pmem_read),
    .l2_pmem_addr     (l2_pmem_addr),
    .l2_pmem_rdata    (l2_pmem_rdata),
    .l2_pmem_resp     (l2_pmem_resp),
    .vc_evict_req     (vc_evict_req),
    .vc_evict_addr    (vc_evict_addr),
    .vc_evict_wdata   (vc_evict_wdata),
    .vc_evict_ack     (vc_evict_ack),
    .vc_dirty_vec     (vc_dirty_vec),
    .vc_way_write     (vc_way_write),
    .vc_way_write_idx (vc_way_write_idx),
    .clean_way        (clean_way),
    .clean_addr       (clean_addr),
    .clean_wdata      (clean_wdata),
    .clean_done       (clean_done),
    .pmem             (pmem_bus)
  );

  // VC line store model: contents depend on the way and a generation
  // counter, so a changed generation exposes an unlatched clean copy.
  function automatic logic [ADDR_W-1:0] vc_addr(input logic [3:0] g, input logic [2:0] w);
    return {4'hC, g, 5'b0, w};
  endfunction
  function automatic logic [LINE_W-1:0] vc_data(input logic [3:0] g, input logic [2:0] w);
    return {8{4'hD, g, 21'h0, w}};
  endfunction
  assign clean_addr  = vc_addr(vc_gen, clean_way);
  assign clean_wdata = vc_data(vc_gen, clean_way);

  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
  } cmd_t;
  cmd_t sb[$];

  typedef struct {
    int                kind;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
    logic [WAYS-1:0]   dirty;
    logic [2:0]        way;
    int                delay;
    logic [LINE_W-1:0] rdata;
  } txn_t;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wait_cmd(output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!(pmem_bus.pmem_read || pmem_bus.pmem_write) && cyc < 10);
  endtask

  task automatic expect_cmd(input string tag);
    cmd_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s_sb: got command with empty scoreboard expected none", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_rd"},   pmem_bus.pmem_read,  !e.wr);
      check({tag, "_wr"},   pmem_bus.pmem_write, e.wr);
      check({tag, "_addr"}, pmem_bus.pmem_address, e.addr);
      if (e.wr) check({tag, "_wdata"}, pmem_bus.pmem_wdata, e.data);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_nocmd"}, {pmem_bus.pmem_read, pmem_bus.pmem_write}, 2'b00);
    check({tag, "_nopulse"}, {l2_pmem_resp, vc_evict_ack, clean_done}, 3'b000);
  endtask

  task automatic drop_all();
    l2_idle        = 1'b0;
    l2_pmem_read   = 1'b0;
    vc_evict_req   = 1'b0;
    vc_dirty_vec   = '0;
    vc_way_write   = 1'b0;
    pmem_bus.pmem_resp = 1'b0;
  endtask

  task automatic run_txn(input int n, input txn_t t);
    int    cyc;
    string tag;
    tag = $sformatf("tbl%0d", n);
    case (t.kind)
      K_FILL: begin
        l2_pmem_read = 1'b1;
        l2_pmem_addr = t.addr;
        sb.push_back(cmd_t'{wr: 1'b0, addr: t.addr, data: '0});
      end
      K_EVICT: begin
        vc_evict_req   = 1'b1;
        vc_evict_addr  = t.addr;
        vc_evict_wdata = t.data;
        sb.push_back(cmd_t'{wr: 1'b1, addr: t.addr, data: t.data});
      end
      default: begin
        l2_idle      = 1'b1;
        vc_dirty_vec = t.dirty;
        sb.push_back(cmd_t'{wr: 1'b1, addr: vc_addr(vc_gen, t.way), data: vc_data(vc_gen, t.way)});
      end
    endcase
    wait_cmd(cyc);
    check({tag, "_lat"}, cyc, 1);
    if (t.kind == K_CLEAN) begin
      check({tag, "_way"}, clean_way, t.way);
      vc_gen       = vc_gen + 4'd1;
      vc_dirty_vec = '0;
      l2_idle      = 1'b0;
      settle();
    end
    expect_cmd(tag);
    for (int i = 1; i < t.delay; i++) step();
    pmem_bus.pmem_rdata = t.rdata;
    pmem_bus.pmem_resp  = 1'b1;
    settle();
    check({tag, "_held"}, pmem_bus.pmem_read | pmem_bus.pmem_write, 1'b1);
    check({tag, "_done"}, {l2_pmem_resp, vc_evict_ack, clean_done},
          {t.kind == K_FILL, t.kind == K_EVICT, t.kind == K_CLEAN});
    if (t.kind == K_FILL) check({tag, "_rdata"}, l2_pmem_rdata, t.rdata);
    step();
    drop_all();
    settle();
    check_quiet({tag, "_idle"});
  endtask

  task automatic stale_case(input logic [2:0] idx, input logic exp_done);
    int cyc;
    l2_idle      = 1'b1;
    vc_dirty_vec = 8'b0000_1000;
    sb.push_back(cmd_t'{wr: 1'b1, addr: vc_addr(vc_gen, 3'd3), data: vc_data(vc_gen, 3'd3)});
    wait_cmd(cyc);
    check("stale_lat", cyc, 1);
    l2_idle          = 1'b0;
    vc_dirty_vec     = '0;
    vc_way_write     = 1'b1;
    vc_way_write_idx = idx;
    settle();
    expect_cmd("stale");
    step();
    vc_way_write = 1'b0;
    step();
    pmem_bus.pmem_resp = 1'b1;
    settle();
    check($sformatf("stale_idx%0d_write", idx), pmem_bus.pmem_write, 1'b1);
    check($sformatf("stale_idx%0d_done", idx), clean_done, exp_done);
    step();
    drop_all();
    settle();
    check_quiet("stale_after");
  endtask

  txn_t tbl[7];

  initial begin
    int cyc;
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    tbl[0] = '{K_FILL,  16'h1200, '0, '0, 3'd0, 3, {8{32'h1200_AAAA}}};
    tbl[1] = '{K_FILL,  16'hFFFF, '0, '0, 3'd0, 1, {8{32'hFFFF_0001}}};
    tbl[2] = '{K_EVICT, 16'h0040, {8{32'hE0E0_0040}}, '0, 3'd0, 2, '0};
    tbl[3] = '{K_CLEAN, '0, '0, 8'b0010_1000, 3'd3, 2, '0};
    tbl[4] = '{K_CLEAN, '0, '0, 8'b0010_0000, 3'd5, 1, '0};
    tbl[5] = '{K_CLEAN, '0, '0, 8'b1000_0000, 3'd7, 3, '0};
    tbl[6] = '{K_FILL,  16'h0000, '0, '0, 3'd0, 4, {8{32'h0BAD_F00D}}};

    rst = 1'b1;
    drop_all();
    l2_pmem_addr        = '0;
    vc_evict_addr       = '0;
    vc_evict_wdata      = '0;
    vc_way_write_idx    = '0;
    pmem_bus.pmem_rdata = '0;
    vc_gen              = 4'd0;
    step();
    step();
    rst = 1'b0;
    settle();
    check("rst_cmd", {pmem_bus.pmem_read, pmem_bus.pmem_write}, 2'b00);
    check("rst_addr", pmem_bus.pmem_address, '0);
    check("rst_wdata", pmem_bus.pmem_wdata, '0);
    check("rst_pulses", {l2_pmem_resp, vc_evict_ack, clean_done}, 3'b000);
    check("rst_l2_rdata", l2_pmem_rdata, '0);
    check("rst_clean_way", clean_way, '0);

    for (int i = 0; i < 7; i++) run_txn(i, tbl[i]);

    // Nothing dirty while L2 idle: arbiter must stay idle.
    l2_idle = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("nodirty_nocmd", {pmem_bus.pmem_read, pmem_bus.pmem_write}, 2'b00);
    end
    drop_all();
    step();

    // Evict and fill requested together: evict, one idle cycle, then fill.
    l2_pmem_read   = 1'b1;
    l2_pmem_addr   = 16'h3456;
    vc_evict_req   = 1'b1;
    vc_evict_addr  = 16'h0ABC;
    vc_evict_wdata = {8{32'hEEEE_0ABC}};
    sb.push_back(cmd_t'{wr: 1'b1, addr: 16'h0ABC, data: {8{32'hEEEE_0ABC}}});
    sb.push_back(cmd_t'{wr: 1'b0, addr: 16'h3456, data: '0});
    wait_cmd(cyc);
    check("ef_lat", cyc, 1);
    expect_cmd("ef_evict");
    pmem_bus.pmem_resp = 1'b1;
    settle();
    check("ef_ack", {vc_evict_ack, l2_pmem_resp}, 2'b10);
    step();
    pmem_bus.pmem_resp = 1'b0;
    vc_evict_req       = 1'b0;
    settle();
    check_quiet("ef_gap");
    step();
    expect_cmd("ef_fill");
    pmem_bus.pmem_rdata = {8{32'h3456_CAFE}};
    pmem_bus.pmem_resp  = 1'b1;
    settle();
    check("ef_fill_resp", l2_pmem_resp, 1'b1);
    check("ef_fill_rdata", l2_pmem_rdata, {8{32'h3456_CAFE}});
    step();
    drop_all();
    settle();
    check_quiet("ef_end");

    // VC write to the way being cleaned suppresses clean_done.
    stale_case(3'd3, 1'b0);
    stale_case(3'd4, 1'b1);

    // L2 fill arriving mid-clean waits for the clean to finish.
    l2_idle      = 1'b1;
    vc_dirty_vec = 8'b0000_0001;
    sb.push_back(cmd_t'{wr: 1'b1, addr: vc_addr(vc_gen, 3'd0), data: vc_data(vc_gen, 3'd0)});
    sb.push_back(cmd_t'{wr: 1'b0, addr: 16'h7777, data: '0});
    wait_cmd(cyc);
    check("mid_lat", cyc, 1);
    l2_idle      = 1'b0;
    vc_dirty_vec = '0;
    settle();
    expect_cmd("mid_clean");
    step();
    l2_pmem_read = 1'b1;
    l2_pmem_addr = 16'h7777;
    settle();
    check("mid_overlap1", {pmem_bus.pmem_read, pmem_bus.pmem_write}, 2'b01);
    step();
    check("mid_overlap2", {pmem_bus.pmem_read, pmem_bus.pmem_write}, 2'b01);
    pmem_bus.pmem_resp = 1'b1;
    settle();
    check("mid_clean_done", {clean_done, l2_pmem_resp}, 2'b10);
    step();
    pmem_bus.pmem_resp = 1'b0;
    settle();
    check_quiet("mid_gap");
    step();
    expect_cmd("mid_fill");
    pmem_bus.pmem_rdata = {8{32'h7777_1234}};
    pmem_bus.pmem_resp  = 1'b1;
    settle();
    check("mid_fill_resp", l2_pmem_resp, 1'b1);
    step();
    drop_all();
    settle();

    // Reset during a fill abandons it; a late pmem_resp is ignored.
    l2_pmem_read = 1'b1;
    l2_pmem_addr = 16'h1111;
    sb.push_back(cmd_t'{wr: 1'b0, addr: 16'h1111, data: '0});
    wait_cmd(cyc);
    check("rf_lat", cyc, 1);
    expect_cmd("rf_fill");
    rst = 1'b1;
    step();
    rst          = 1'b0;
    l2_pmem_read = 1'b0;
    settle();
    check_quiet("rf_reset");
    pmem_bus.pmem_resp = 1'b1;
    settle();
    check("rf_late_resp", {l2_pmem_resp, pmem_bus.pmem_read}, 2'b00);
    step();
    check("rf_still_idle", {l2_pmem_resp, pmem_bus.pmem_read, pmem_bus.pmem_write}, 3'b000);
    pmem_bus.pmem_resp = 1'b0;
    step();

    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
